// File: rtl/sobel_frame_loader.sv
// Raster stream to BRAM0 frame loader feeding the Sobel FSM: stores one frame, pulses complete,
// holds the buffer until released. Define SOBEL_FRAME_LOADER_AUTORESTART_EN to re-arm on release.
module sobel_frame_loader #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned IMAGE_WIDTH  = 279,
  parameter int unsigned IMAGE_HEIGHT = 210,
  parameter int unsigned IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_release,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] b0_d0,
  output logic                  b0_ce0,
  output logic                  b0_we0,
  output logic [ADDR_WIDTH-1:0] b0_addr0,
  output logic                  o_complete,
  output logic [ADDR_WIDTH-1:0] o_num_cnt,
  output logic                  o_idle,
  output logic                  o_err
);

  typedef enum logic [2:0] {StIdle, StWaitSof, StLoad, StDone, StHold} state_e;

  localparam logic [ADDR_WIDTH-1:0] SizeLim = ADDR_WIDTH'(IMAGE_SIZE);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  s_ready_q, ce_q, complete_q, idle_q, err_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic [ADDR_WIDTH-1:0] addr_q, num_cnt_q;

  logic                  accept, store;
  logic [ADDR_WIDTH-1:0] wr_addr, cnt_next;

  assign accept = s_valid && s_ready_q;
  // In WaitSof only an s_sof beat is stored; every accepted beat in Load is stored.
  assign store  = accept && (s_sof || (state_q == StLoad));

  // An s_sof beat always restarts the frame at address 0 (cnt_q is already 0 in WaitSof).
  always_comb begin
    wr_addr  = s_sof ? '0 : cnt_q;
    cnt_next = wr_addr + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      s_ready_q  <= 1'b0;
      ce_q       <= 1'b0;
      d_q        <= '0;
      addr_q     <= '0;
      complete_q <= 1'b0;
      num_cnt_q  <= '0;
      idle_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      ce_q       <= 1'b0;
      complete_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            err_q     <= 1'b0;
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
            idle_q    <= 1'b0;
            state_q   <= StWaitSof;
          end
        end
        StWaitSof, StLoad: begin
          if (store) begin
            ce_q   <= 1'b1;
            d_q    <= s_data;
            addr_q <= wr_addr;
            cnt_q  <= cnt_next;
            if (state_q == StLoad && s_sof) err_q <= 1'b1;
            if (s_last || cnt_next == SizeLim) begin
              // Only an s_last landing exactly on the full frame size is a clean frame.
              if (!(s_last && cnt_next == SizeLim)) err_q <= 1'b1;
              s_ready_q <= 1'b0;
              state_q   <= StDone;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StDone: begin
          complete_q <= 1'b1;
          num_cnt_q  <= cnt_q;
          state_q    <= StHold;
        end
        StHold: begin
          if (i_release) begin
`ifdef SOBEL_FRAME_LOADER_AUTORESTART_EN
            err_q     <= 1'b0;
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
            state_q   <= StWaitSof;
`else
            idle_q  <= 1'b1;
            state_q <= StIdle;
`endif
          end
        end
        default: begin
          s_ready_q <= 1'b0;
          idle_q    <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign b0_d0      = d_q;
  assign b0_ce0     = ce_q;
  assign b0_we0     = ce_q;
  assign b0_addr0   = addr_q;
  assign o_complete = complete_q;
  assign o_num_cnt  = num_cnt_q;
  assign o_idle     = idle_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_sobel_frame_loader.sv
// Randomized self-checking bench for sobel_frame_loader against a beat-list frame model.
// The frame size is scaled down (23 x 9) so every scenario runs a complete frame quickly.
module tb_sobel_frame_loader;

  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int IW   = 23;
  localparam int IH   = 9;
  localparam int SIZE = IW * IH;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_release;
  logic          s_valid, s_ready, s_sof, s_last;
  logic [DW-1:0] s_data;
  logic [DW-1:0] b0_d0;
  logic          b0_ce0, b0_we0;
  logic [AW-1:0] b0_addr0;
  logic          o_complete, o_idle, o_err;
  logic [AW-1:0] o_num_cnt;

  sobel_frame_loader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .IMAGE_WIDTH (IW),
    .IMAGE_HEIGHT(IH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_release (i_release),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .s_last    (s_last),
    .b0_d0     (b0_d0),
    .b0_ce0    (b0_ce0),
    .b0_we0    (b0_we0),
    .b0_addr0  (b0_addr0),
    .o_complete(o_complete),
    .o_num_cnt (o_num_cnt),
    .o_idle    (o_idle),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observed BRAM writes and complete pulses
  int unsigned wr_addr_q[$];
  int unsigned wr_data_q[$];
  int          cmp_cyc_q[$];
  int unsigned cmp_cnt_q[$];
  logic        cmp_err_q[$];

  always @(negedge clk) begin
    if (b0_ce0 && b0_we0) begin
      wr_addr_q.push_back(int'(b0_addr0));
      wr_data_q.push_back(int'(b0_d0));
    end
    if (o_complete) begin
      cmp_cyc_q.push_back(cyc);
      cmp_cnt_q.push_back(int'(o_num_cnt));
      cmp_err_q.push_back(o_err);
    end
  end

  // Stimulus beats and model expectations
  logic [DW-1:0] bd[$];
  bit            bs[$];
  bit            bl[$];
  int unsigned   exp_addr[$];
  int unsigned   exp_data[$];
  int            exp_cnt;
  bit            exp_err;
  int            last_acc_cyc;

  function automatic void clear_all();
    bd.delete(); bs.delete(); bl.delete();
    wr_addr_q.delete(); wr_data_q.delete();
    cmp_cyc_q.delete(); cmp_cnt_q.delete(); cmp_err_q.delete();
  endfunction

  function automatic void push_beat(bit sof, bit last);
    bd.push_back(DW'($urandom));
    bs.push_back(sof);
    bl.push_back(last);
  endfunction

  // Frame rules: nothing stored before the first sof; a later sof restarts at address 0 and
  // flags an error; the frame ends at last or at SIZE pixels, and is clean only at last == SIZE.
  function automatic void model();
    bit started = 0;
    int c = 0;
    exp_addr.delete(); exp_data.delete();
    exp_err = 0;
    foreach (bd[i]) begin
      if (!started) begin
        if (!bs[i]) continue;
        started = 1;
      end else if (bs[i]) begin
        exp_err = 1;
        c = 0;
      end
      exp_addr.push_back(c);
      exp_data.push_back(int'(bd[i]));
      c++;
      if (bl[i]) begin
        if (c < SIZE) exp_err = 1;
        break;
      end
      if (c == SIZE) begin
        exp_err = 1;
        break;
      end
    end
    exp_cnt = c;
  endfunction

  function automatic int wr_diff();
    int m, n;
    m = (wr_addr_q.size() > exp_addr.size()) ? wr_addr_q.size() - exp_addr.size()
                                             : exp_addr.size() - wr_addr_q.size();
    n = (wr_addr_q.size() < exp_addr.size()) ? wr_addr_q.size() : exp_addr.size();
    for (int i = 0; i < n; i++)
      if (wr_addr_q[i] != exp_addr[i] || wr_data_q[i] != exp_data[i]) m++;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic release_buffer();
    i_release = 1'b1;
    tick();
    i_release = 1'b0;
  endtask

  // Sends beats (stopping before index stop_at if >= 0); a beat not taken within 8 cycles stalls.
  task automatic drive_frame(int gap_max, int stop_at, output int n_acc, output bit stalled);
    int w;
    n_acc = 0;
    stalled = 0;
    foreach (bd[i]) begin
      if (stop_at >= 0 && i == stop_at) break;
      repeat ($urandom_range(gap_max, 0)) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1; s_data = bd[i]; s_sof = bs[i]; s_last = bl[i];
      w = 0;
      while (!s_ready && w < 8) begin
        tick();
        w++;
      end
      if (!s_ready) begin
        stalled = 1;
        break;
      end
      tick();
      n_acc++;
      last_acc_cyc = cyc - 1;
    end
    s_valid = 1'b0; s_sof = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_complete(int budget);
    int k = 0;
    while (cmp_cyc_q.size() == 0 && k < budget) begin
      tick();
      k++;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 0; i_release = 0; s_valid = 0; s_sof = 0; s_last = 0; s_data = '0;
    repeat (3) tick();
    checks++;
    if ({s_ready, b0_ce0, b0_we0, o_complete, o_err, o_idle} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000001",
               {s_ready, b0_ce0, b0_we0, o_complete, o_err, o_idle});
    end
    checks++;
    if (b0_addr0 !== '0 || b0_d0 !== '0 || o_num_cnt !== '0) begin
      errors++;
      $display("FAIL reset_buses: addr %0h d0 %0h cnt %0h want 0", b0_addr0, b0_d0, o_num_cnt);
    end
    rst = 1'b0;
    tick();
    release_buffer();
    checks++;
    if (o_idle !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL release_in_idle: idle %b ready %b want 1 0", o_idle, s_ready);
    end
  endtask

  task automatic test_full_frame();
    int n; bit st;
    clear_all();
    for (int i = 0; i < SIZE; i++) push_beat(i == 0, i == SIZE - 1);
    model();
    start_frame();
    drive_frame(0, -1, n, st);
    wait_complete(10);
    checks++;
    if (wr_diff() !== 0) begin
      errors++;
      $display("FAIL full_writes: %0d bad of %0d got, want %0d", wr_diff(), wr_addr_q.size(),
               exp_addr.size());
    end
    checks++;
    if (cmp_cyc_q.size() !== 1) begin
      errors++;
      $display("FAIL full_pulses: got %0d want 1", cmp_cyc_q.size());
    end else begin
      checks++;
      if (cmp_cyc_q[0] !== last_acc_cyc + 2) begin
        errors++;
        $display("FAIL full_latency: got cycle %0d want %0d", cmp_cyc_q[0], last_acc_cyc + 2);
      end
      checks++;
      if (cmp_cnt_q[0] !== exp_cnt || cmp_err_q[0] !== exp_err) begin
        errors++;
        $display("FAIL full_cnt_err: got %0d/%b want %0d/%b", cmp_cnt_q[0], cmp_err_q[0],
                 exp_cnt, exp_err);
      end
    end
    checks++;
    if (o_num_cnt !== AW'(SIZE) || s_ready !== 1'b0 || o_idle !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: cnt %0d ready %b idle %b want %0d 0 0", o_num_cnt, s_ready,
               o_idle, SIZE);
    end
    release_buffer();
  endtask

  task automatic test_drop_before_sof();
    int n; bit st;
    clear_all();
    repeat (5) push_beat(0, 0);
    for (int i = 0; i < SIZE; i++) push_beat(i == 0, i == SIZE - 1);
    model();
    start_frame();
    drive_frame(2, -1, n, st);
    wait_complete(10);
    checks++;
    if (wr_diff() !== 0) begin
      errors++;
      $display("FAIL drop_writes: %0d bad, got %0d want %0d", wr_diff(), wr_addr_q.size(),
               exp_addr.size());
    end
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 0 || wr_data_q[0] !== int'(bd[5])) begin
      errors++;
      $display("FAIL drop_first: got %0d entries, want addr 0 data %0h", wr_addr_q.size(), bd[5]);
    end
    checks++;
    if (cmp_cnt_q.size() !== 1 || o_num_cnt !== AW'(exp_cnt) || o_err !== exp_err) begin
      errors++;
      $display("FAIL drop_cnt_err: pulses %0d cnt %0d err %b want 1 %0d %b", cmp_cnt_q.size(),
               o_num_cnt, o_err, exp_cnt, exp_err);
    end
    release_buffer();
  endtask

  task automatic test_short_frame();
    int n; bit st;
    clear_all();
    for (int i = 0; i < 100; i++) push_beat(i == 0, i == 99);
    model();
    start_frame();
    drive_frame(1, -1, n, st);
    wait_complete(10);
    checks++;
    if (wr_diff() !== 0 || wr_addr_q.size() !== 100) begin
      errors++;
      $display("FAIL short_writes: %0d bad, got %0d want 100", wr_diff(), wr_addr_q.size());
    end
    checks++;
    if (cmp_cnt_q.size() !== 1 || o_num_cnt !== AW'(100) || o_err !== 1'b1) begin
      errors++;
      $display("FAIL short_cnt_err: pulses %0d cnt %0d err %b want 1 100 1", cmp_cnt_q.size(),
               o_num_cnt, o_err);
    end
    release_buffer();
  endtask

  task automatic test_mid_sof();
    int n; bit st;
    clear_all();
    for (int i = 0; i < 49; i++) push_beat(i == 0, 0);
    for (int i = 0; i < SIZE; i++) push_beat(i == 0, i == SIZE - 1);
    model();
    start_frame();
    drive_frame(1, -1, n, st);
    wait_complete(10);
    checks++;
    if (wr_diff() !== 0) begin
      errors++;
      $display("FAIL midsof_writes: %0d bad, got %0d want %0d", wr_diff(), wr_addr_q.size(),
               exp_addr.size());
    end
    checks++;
    if (wr_addr_q.size() < 50 || wr_addr_q[49] !== 0 || wr_data_q[49] !== int'(bd[49])) begin
      errors++;
      $display("FAIL midsof_restart: got %0d entries, want beat 50 at addr 0 data %0h",
               wr_addr_q.size(), bd[49]);
    end
    checks++;
    if (cmp_cnt_q.size() !== 1 || o_num_cnt !== AW'(SIZE) || o_err !== 1'b1) begin
      errors++;
      $display("FAIL midsof_cnt_err: pulses %0d cnt %0d err %b want 1 %0d 1", cmp_cnt_q.size(),
               o_num_cnt, o_err, SIZE);
    end
    release_buffer();
  endtask

  task automatic test_overlong();
    int n; bit st;
    clear_all();
    for (int i = 0; i < SIZE + 4; i++) push_beat(i == 0, 0);
    model();
    start_frame();
    drive_frame(0, -1, n, st);
    wait_complete(10);
    checks++;
    if (st !== 1'b1 || n !== SIZE) begin
      errors++;
      $display("FAIL overlong_stall: stalled %b accepted %0d want 1 %0d", st, n, SIZE);
    end
    checks++;
    if (wr_diff() !== 0) begin
      errors++;
      $display("FAIL overlong_writes: %0d bad, got %0d want %0d", wr_diff(), wr_addr_q.size(),
               exp_addr.size());
    end
    checks++;
    if (cmp_cnt_q.size() !== 1 || o_num_cnt !== AW'(exp_cnt) || o_err !== 1'b1) begin
      errors++;
      $display("FAIL overlong_cnt_err: pulses %0d cnt %0d err %b want 1 %0d 1",
               cmp_cnt_q.size(), o_num_cnt, o_err, exp_cnt);
    end
  endtask

  // Entered in HOLD with o_err set by the overlong frame.
  task automatic test_hold_release();
    int bad_ready = 0;
    int nw;
    start_frame();
    checks++;
    if (o_err !== 1'b1 || o_idle !== 1'b0) begin
      errors++;
      $display("FAIL hold_start_ignored: err %b idle %b want 1 0", o_err, o_idle);
    end
    nw = wr_addr_q.size();
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_sof = (i == 0); s_last = (i == 9); s_data = DW'($urandom);
      if (s_ready !== 1'b0) bad_ready++;
      tick();
    end
    s_valid = 1'b0; s_sof = 1'b0; s_last = 1'b0;
    tick();
    checks++;
    if (bad_ready !== 0 || wr_addr_q.size() !== nw) begin
      errors++;
      $display("FAIL hold_quiet: ready-high cycles %0d new writes %0d want 0 0", bad_ready,
               wr_addr_q.size() - nw);
    end
    release_buffer();
`ifdef SOBEL_FRAME_LOADER_AUTORESTART_EN
    checks++;
    if (o_idle !== 1'b0 || s_ready !== 1'b1 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL release_rearm: idle %b ready %b err %b want 0 1 0", o_idle, s_ready, o_err);
    end
`else
    checks++;
    if (o_idle !== 1'b1 || s_ready !== 1'b0 || o_err !== 1'b1) begin
      errors++;
      $display("FAIL release_idle: idle %b ready %b err %b want 1 0 1", o_idle, s_ready, o_err);
    end
`endif
  endtask

  task automatic test_reset_mid_load();
    int n, nw, bad_ready;
    bit st;
    clear_all();
    for (int i = 0; i < SIZE; i++) push_beat(i == 0, i == SIZE - 1);
    start_frame();
    drive_frame(3, 100, n, st);
    rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, b0_ce0, b0_we0, o_complete, o_err, o_idle} !== 6'b000001 ||
        b0_addr0 !== '0 || b0_d0 !== '0 || o_num_cnt !== '0) begin
      errors++;
      $display("FAIL midload_reset: flags %b addr %0h d0 %0h cnt %0h want 000001 0 0 0",
               {s_ready, b0_ce0, b0_we0, o_complete, o_err, o_idle}, b0_addr0, b0_d0, o_num_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
    nw = wr_addr_q.size();
    bad_ready = 0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_sof = 1'b1; s_last = 1'b0; s_data = DW'($urandom);
      if (s_ready !== 1'b0) bad_ready++;
      tick();
    end
    s_valid = 1'b0; s_sof = 1'b0;
    repeat (3) tick();
    checks++;
    if (bad_ready !== 0 || wr_addr_q.size() !== nw || cmp_cyc_q.size() !== 0) begin
      errors++;
      $display("FAIL midload_after: ready-high %0d new writes %0d pulses %0d want 0 0 0",
               bad_ready, wr_addr_q.size() - nw, cmp_cyc_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_drop_before_sof();
    test_short_frame();
    test_mid_sof();
    test_overlong();
    test_hold_release();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
